// File: rtl/match_victory.sv
// Best-of-N tug-of-war match controller: detects round wins, keeps per-player
// scores, holds the playfield in reset between rounds and latches the match winner.
module match_victory #(
  parameter int unsigned WIN_ROUNDS  = 3,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               leftKey,
  input  logic               rightKey,
  input  logic               leftLED,
  input  logic               rightLED,
  input  logic               newMatch,
  output logic [SCORE_W-1:0] p1Score,
  output logic [SCORE_W-1:0] p2Score,
  output logic               roundWin1,
  output logic               roundWin2,
  output logic               player1Win,
  output logic               player2Win,
  output logic               playfieldReset
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [SCORE_W-1:0] WIN_SC    = SCORE_W'(WIN_ROUNDS);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic               rw1_q, rw1_d, rw2_q, rw2_d;
  logic               w1_q, w1_d, w2_q, w2_d;

  logic               win_l, win_r;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

  // Both keys down is a contested press and never scores.
  assign win_l  = leftLED  & leftKey  & ~rightKey;
  assign win_r  = rightLED & rightKey & ~leftKey;
  assign p1_inc = p1_q + 1'b1;
  assign p2_inc = p2_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    rw1_d   = 1'b0;
    rw2_d   = 1'b0;
    w1_d    = w1_q;
    w2_d    = w2_q;
    case (state_q)
      S_PLAY: begin
        if (newMatch) begin
          p1_d = '0;
          p2_d = '0;
        end else if (win_l) begin
          p1_d  = p1_inc;
          rw1_d = 1'b1;
          if (p1_inc == WIN_SC) begin
            state_d = S_OVER;
            w1_d    = 1'b1;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else if (win_r) begin
          p2_d  = p2_inc;
          rw2_d = 1'b1;
          if (p2_inc == WIN_SC) begin
            state_d = S_OVER;
            w2_d    = 1'b1;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (newMatch) begin
          p1_d    = '0;
          p2_d    = '0;
          state_d = S_PLAY;
        end else if (cnt_q == '0) begin
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OVER: begin
        if (newMatch) begin
          p1_d    = '0;
          p2_d    = '0;
          w1_d    = 1'b0;
          w2_d    = 1'b0;
          state_d = S_PLAY;
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_PLAY;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      rw1_q   <= 1'b0;
      rw2_q   <= 1'b0;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      rw1_q   <= rw1_d;
      rw2_q   <= rw2_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
    end
  end

  assign p1Score        = p1_q;
  assign p2Score        = p2_q;
  assign roundWin1      = rw1_q;
  assign roundWin2      = rw2_q;
  assign player1Win     = w1_q;
  assign player2Win     = w2_q;
  assign playfieldReset = (state_q != S_PLAY);

endmodule

// File: tb/tb_match_victory.sv
// Bench for match_victory: directed scenarios then random play, all outputs
// compared every cycle against a score/pause-count reference model.
module tb_match_victory;

  localparam int WIN  = 3;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       leftKey = 1'b0, rightKey = 1'b0, leftLED = 1'b0, rightLED = 1'b0;
  logic       newMatch = 1'b0;
  logic [2:0] p1Score, p2Score;
  logic       roundWin1, roundWin2, player1Win, player2Win, playfieldReset;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: scores, match winner (0 none), remaining pause cycles, pulse owner
  int m_s1, m_s2, m_winner, m_pause, m_rw;

  match_victory #(.WIN_ROUNDS(3), .SCORE_W(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .leftKey(leftKey), .rightKey(rightKey), .leftLED(leftLED), .rightLED(rightLED),
    .newMatch(newMatch),
    .p1Score(p1Score), .p2Score(p2Score),
    .roundWin1(roundWin1), .roundWin2(roundWin2),
    .player1Win(player1Win), .player2Win(player2Win),
    .playfieldReset(playfieldReset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_winner = 0; m_pause = 0; m_rw = 0;
  endtask

  task automatic model_step(input bit lk, input bit rk, input bit ll, input bit rl, input bit nm);
    m_rw = 0;
    if (m_winner != 0) begin
      if (nm) begin m_s1 = 0; m_s2 = 0; m_winner = 0; end
    end else if (m_pause > 0) begin
      if (nm) begin m_s1 = 0; m_s2 = 0; m_pause = 0; end
      else m_pause--;
    end else if (nm) begin
      m_s1 = 0; m_s2 = 0;
    end else if (ll && lk && !rk) begin
      m_s1++; m_rw = 1;
      if (m_s1 == WIN) m_winner = 1; else m_pause = HOLD;
    end else if (rl && rk && !lk) begin
      m_s2++; m_rw = 2;
      if (m_s2 == WIN) m_winner = 2; else m_pause = HOLD;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".p1Score"},   32'(p1Score),        32'(m_s1));
    check({tag, ".p2Score"},   32'(p2Score),        32'(m_s2));
    check({tag, ".roundWin1"}, 32'(roundWin1),      32'(m_rw == 1));
    check({tag, ".roundWin2"}, 32'(roundWin2),      32'(m_rw == 2));
    check({tag, ".p1Win"},     32'(player1Win),     32'(m_winner == 1));
    check({tag, ".p2Win"},     32'(player2Win),     32'(m_winner == 2));
    check({tag, ".pfReset"},   32'(playfieldReset), 32'(m_winner != 0 || m_pause > 0));
  endtask

  // Drive inputs for one cycle, clock, update model, compare 1 time unit later.
  task automatic cycle(input string tag, input bit lk, input bit rk, input bit ll,
                       input bit rl, input bit nm);
    leftKey = lk; rightKey = rk; leftLED = ll; rightLED = rl; newMatch = nm;
    @(posedge clk);
    model_step(lk, rk, ll, rl, nm);
    #1;
    check_all(tag);
    leftKey = 0; rightKey = 0; leftLED = 0; rightLED = 0; newMatch = 0;
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 reset = 1'b1;
  endtask

  int pf_cnt;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mid_cycle_reset("por");
    for (int i = 0; i < 3; i++) cycle("idle", 0, 0, 0, 0, 0);

    // single round win, keys pulsed during hold
    cycle("winL", 1, 0, 1, 0, 0);
    check("winL.p1", 32'(p1Score), 1);
    check("winL.rw1", 32'(roundWin1), 1);
    pf_cnt = playfieldReset ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      cycle("holdkeys", 1, (i == 1), 1, (i == 1), 0);
      if (playfieldReset) pf_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      cycle("holdend", 0, 0, 0, 0, 0);
      if (playfieldReset) pf_cnt++;
    end
    check("hold_len", 32'(pf_cnt), 4);

    // contested press
    for (int i = 0; i < 5; i++) cycle("contest", 1, 1, 1, 0, 0);
    check("contest.p1", 32'(p1Score), 1);

    // match win by player 2
    cycle("clr", 0, 0, 0, 0, 1);
    for (int r = 0; r < 3; r++) begin
      cycle("winR", 0, 1, 0, 1, 0);
      if (r < 2) for (int i = 0; i < 4; i++) cycle("hold2", 0, 0, 0, 0, 0);
    end
    check("match.p2", 32'(p2Score), 3);
    check("match.p2Win", 32'(player2Win), 1);
    check("match.pf", 32'(playfieldReset), 1);
    cycle("over_press", 0, 1, 0, 1, 0);
    check("over.p2", 32'(p2Score), 3);
    cycle("newmatch", 0, 0, 0, 0, 1);
    check("nm.p2Win", 32'(player2Win), 0);

    // newMatch on second hold cycle
    cycle("winL2", 1, 0, 1, 0, 0);
    cycle("hold1", 0, 0, 0, 0, 0);
    cycle("nm_hold", 0, 0, 0, 0, 1);
    check("nmhold.pf", 32'(playfieldReset), 0);
    check("nmhold.p1", 32'(p1Score), 0);

    // newMatch collides with a win in PLAY
    cycle("nm_vs_win", 1, 0, 1, 0, 1);

    // reset in the middle of hold with p2Score=2
    cycle("r1", 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle("rh", 0, 0, 0, 0, 0);
    cycle("r2", 0, 1, 0, 1, 0);
    cycle("rh2", 0, 0, 0, 0, 0);
    check("prerst.p2", 32'(p2Score), 2);
    mid_cycle_reset("rst_hold");
    cycle("postrst", 0, 1, 0, 1, 0);
    check("postrst.p2", 32'(p2Score), 1);

    // random play
    for (int i = 0; i < 4000; i++) begin
      bit lk, rk, ll, rl, nm;
      lk = ($urandom % 2) == 0;
      rk = ($urandom % 2) == 0;
      ll = ($urandom % 3) == 0;
      rl = ($urandom % 3) == 0;
      nm = ($urandom % 40) == 0;
      cycle("rand", lk, rk, ll, rl, nm);
      if (($urandom % 500) == 0) mid_cycle_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_victory.md
# match_victory

Best-of-N match controller for the tug-of-war game. It replaces the single-round winner latch. It detects a round win when the light is at a player's end and that player alone presses, then updates per-player round scores. After a round it holds the playfield in reset for a programmable number of cycles, and latches a match winner once a player reaches the target score. It sits between the playfield LED chain and the HEX/score display logic, and drives the playfield reset line.

## Interface
- `WIN_ROUNDS`, default 3: round wins needed to win the match. Legal range is 1 to 2^SCORE_W−1.
- `SCORE_W`, default 3: width of each score counter.
- `HOLD_CYCLES`, default 4: cycles the playfield is held in reset after a non-final round win. Must be ≥1.

Ports:
- `clk` in, 1: system clock. All logic is on the rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `leftKey` in, 1: left player key, level, already synchronised.
- `rightKey` in, 1: right player key, level, already synchronised.
- `leftLED` in, 1: light is at the leftmost playfield position.
- `rightLED` in, 1: light is at the rightmost playfield position.
- `newMatch` in, 1: single-cycle request to clear scores and start a new match.
- `p1Score` out, SCORE_W: player 1 (left) round wins.
- `p2Score` out, SCORE_W: player 2 (right) round wins.
- `roundWin1` out, 1: one-cycle pulse when player 1 takes a round.
- `roundWin2` out, 1: one-cycle pulse when player 2 takes a round.
- `player1Win` out, 1: player 1 has won the match. Level.
- `player2Win` out, 1: player 2 has won the match. Level.
- `playfieldReset` out, 1: high while the playfield must be held in reset.

## Operation
- States:
  - PLAY: normal play.
  - HOLD: post-round pause.
  - MATCH_OVER: a player has won the match.
- Hold counter: a down-counter of width clog2(HOLD_CYCLES)+1.
- Win conditions:
  - winL = leftLED & leftKey & ~rightKey.
  - winR = rightLED & rightKey & ~leftKey.
  - The two are mutually exclusive by construction. Both keys pressed means no win.
- PLAY, priority order:
  1. newMatch: scores go to 0; stay in PLAY.
  2. winL: p1Score increments and roundWin1 pulses.
     - If the new p1Score equals WIN_ROUNDS, go to MATCH_OVER and set player1Win.
     - Otherwise go to HOLD with the counter loaded to HOLD_CYCLES−1.
  3. winR: same as winL, using p2Score, roundWin2 and player2Win.
- HOLD:
  - Keys and LEDs are ignored.
  - newMatch: scores go to 0; go to PLAY.
  - Otherwise, if the counter is 0, go to PLAY; else decrement the counter.
- MATCH_OVER:
  - Keys and LEDs are ignored. Scores and player1Win/player2Win hold their values.
  - newMatch: scores, player1Win and player2Win all clear; go to PLAY.
- Score arithmetic:
  - Unsigned, SCORE_W bits.
  - A score never exceeds WIN_ROUNDS, so it never wraps.
  - At most one score changes per cycle.
- Output decoding:
  - playfieldReset is a decode of the registered state: high when state ≠ PLAY. It is glitch-free.
  - roundWin1/roundWin2 are registered pulses.
- Exclusivity: player1Win and player2Win are never both high. roundWin1 and roundWin2 are never both high.
- Reset (reset low, asynchronous, at any time including mid-HOLD):
  - State goes to PLAY and the counter to 0.
  - p1Score and p2Score go to 0.
  - roundWin1, roundWin2, player1Win, player2Win and playfieldReset go to 0.
  - This happens immediately, without waiting for a clock edge.
- Leaving reset: the first rising edge after reset goes high samples inputs normally.

## Timing
- Win latency:
  - Inputs are sampled at edge N.
  - After edge N: score updated, roundWinX high, playfieldReset high.
  - roundWinX falls after edge N+1.
- HOLD length: playfieldReset is high for exactly HOLD_CYCLES cycles (edges N+1 … N+HOLD_CYCLES leave HOLD).
  - After edge N+HOLD_CYCLES: PLAY, playfieldReset low.
  - The first sampled win can occur at edge N+HOLD_CYCLES+1.
- Match win: player1Win/player2Win rise after edge N, together with the final roundWin pulse. They stay high until newMatch or reset.
- newMatch latency: newMatch is sampled at edge M. After edge M the state is PLAY, scores are 0 and win flags are 0.
- Held key: a key held through HOLD and back into PLAY with the LED still at the end counts as a new round win. Upstream is responsible for releasing the playfield before that happens.
- newMatch in the same cycle as a win condition in PLAY: newMatch wins. Scores go to 0 and no roundWin pulse is produced.

## Test plan
- Power-up and idle:
  - Drive reset low between clock edges.
  - Required: all outputs 0 before the next edge.
  - Then release reset and idle 3 cycles with all inputs 0.
  - Required: outputs stay 0.
- Round win (defaults WIN_ROUNDS=3, HOLD_CYCLES=4):
  - Drive leftLED=1, leftKey=1 for one cycle.
  - Required: p1Score=1, roundWin1 high for exactly 1 cycle, playfieldReset high for exactly 4 cycles.
  - Keys pulsed during HOLD have no effect on the scores.
- Contested press:
  - Drive leftLED=1, leftKey=1, rightKey=1 for 5 cycles.
  - Required: no roundWin pulse, scores unchanged, playfieldReset=0.
- Match win:
  - Player 2 wins 3 rounds, each after HOLD expires.
  - Required: p2Score=3, player2Win=1, playfieldReset stays high.
  - A further rightKey/rightLED press leaves p2Score=3.
  - Then pulse newMatch; one cycle later all outputs are 0.
- newMatch during HOLD:
  - After p1Score=1, pulse newMatch on the 2nd HOLD cycle.
  - Required: next cycle PLAY, playfieldReset=0, p1Score=0.
- Reset mid-hold:
  - Assert reset during HOLD with p2Score=2.
  - Required: immediate return to all outputs 0. After release, a win sets the score to 1, not 3.
